// File: rtl/instruction_cache_controller.sv
// Direct-mapped, read-only instruction cache between fetch and a 128-bit block memory.
// Hits are served in the same cycle; a miss issues one block read and refills the line.
module instruction_cache_controller #(
  parameter int INDEX_BITS    = 3,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic [31:0]              cpu_address,
  output logic [31:0]              cpu_readdata,
  output logic                     cpu_busywait,
  output logic                     mem_read,
  output logic [27:0]              mem_address,
  input  logic [127:0]             mem_readdata,
  input  logic                     mem_busywait,
  output logic [COUNTER_WIDTH-1:0] hit_count,
  output logic [COUNTER_WIDTH-1:0] miss_count
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_first;
  logic [LINES-1:0]         r_valid;
  logic [TAG_BITS-1:0]      r_tag [LINES];
  logic [127:0]             r_data [LINES];
  logic [27:0]              r_mem_address;
  logic [COUNTER_WIDTH-1:0] r_hit_count;
  logic [COUNTER_WIDTH-1:0] r_miss_count;

  logic [INDEX_BITS-1:0]    w_index;
  logic [TAG_BITS-1:0]      w_tag;
  logic [INDEX_BITS-1:0]    w_fill_index;
  logic [TAG_BITS-1:0]      w_fill_tag;
  logic                     w_hit;
  logic                     w_miss;
  logic                     w_fill;
  logic                     w_busywait;
  logic                     w_mem_read;
  logic [1:0]               w_unused_addr_bits;

  assign w_index            = cpu_address[3+INDEX_BITS:4];
  assign w_tag              = cpu_address[31:4+INDEX_BITS];
  assign w_fill_index       = r_mem_address[INDEX_BITS-1:0];
  assign w_fill_tag         = r_mem_address[27:INDEX_BITS];
  assign w_unused_addr_bits = cpu_address[1:0];

  assign w_hit  = cpu_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_miss = (r_state == S_IDLE) & cpu_read & ~w_hit;
  // The memory only raises busywait after seeing mem_read, so the first MEM_READ cycle is skipped.
  assign w_fill = (r_state == S_MEM_READ) & ~r_first & ~mem_busywait;

  assign cpu_readdata = r_data[w_index][{cpu_address[3:2], 5'b00000} +: 32];
  assign cpu_busywait = w_busywait;
  assign mem_read     = w_mem_read;
  assign mem_address  = r_mem_address;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

  // Next-state and stall/request decode
  always_comb begin
    w_next_state = r_state;
    w_busywait   = 1'b0;
    w_mem_read   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busywait = cpu_read & ~w_hit;
        if (cpu_read & ~w_hit) begin
          w_next_state = S_MEM_READ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_busywait = 1'b1;
        if (w_fill) begin
          w_next_state = S_UPDATE;
        end else begin
          w_next_state = S_MEM_READ;
        end
      end
      S_UPDATE: begin
        w_busywait   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, valid bits, latched miss address and saturating statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_first       <= 1'b0;
      r_valid       <= '0;
      r_mem_address <= 28'd0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state <= w_next_state;
      r_first <= (r_state != S_MEM_READ);
      if (w_miss) begin
        r_mem_address <= cpu_address[31:4];
        if (r_miss_count != {COUNTER_WIDTH{1'b1}}) begin
          r_miss_count <= r_miss_count + COUNTER_WIDTH'(1);
        end
      end
      if ((r_state == S_IDLE) && w_hit && (r_hit_count != {COUNTER_WIDTH{1'b1}})) begin
        r_hit_count <= r_hit_count + COUNTER_WIDTH'(1);
      end
      if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_data[w_fill_index] <= mem_readdata;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed + randomized bench for instruction_cache_controller with a latency-randomized
// block memory and a line-level reference model of the cache contents.
module tb_instruction_cache_controller;

  logic         clock;
  logic         reset;
  logic         cpu_read;
  logic [31:0]  cpu_address;
  logic [31:0]  cpu_readdata,  cpu_readdata4;
  logic         cpu_busywait,  cpu_busywait4;
  logic         mem_read,      mem_read4;
  logic [27:0]  mem_address,   mem_address4;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [15:0]  hit_count,     miss_count;
  logic [3:0]   hit_count4,    miss_count4;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  int unsigned line_blk [int];
  int h, m;

  instruction_cache_controller #(.INDEX_BITS(3), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait), .mem_read(mem_read),
    .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy fed the same stimulus; its control behaviour is identical
  instruction_cache_controller #(.INDEX_BITS(3), .COUNTER_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_readdata(cpu_readdata4), .cpu_busywait(cpu_busywait4), .mem_read(mem_read4),
    .mem_address(mem_address4), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] block_of(input logic [27:0] ba);
    logic [9:0] w;
    w = {ba[7:0], 2'b00};
    return {mem[w + 10'd3], mem[w + 10'd2], mem[w + 10'd1], mem[w]};
  endfunction

  // Block memory: busy from the cycle after mem_read is seen, random latency, junk data until ready
  int mstate, mcnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_busywait <= 1'b0;
      mstate       <= 0;
      mcnt         <= 0;
    end else begin
      case (mstate)
        0: if (mem_read) begin
          mem_busywait <= 1'b1;
          mem_readdata <= {$urandom, $urandom, $urandom, $urandom};
          mcnt         <= $urandom_range(0, 4);
          mstate       <= 1;
        end
        1: if (mcnt == 0) begin
          mem_busywait <= 1'b0;
          mem_readdata <= block_of(mem_address);
          mstate       <= 2;
        end else begin
          mcnt <= mcnt - 1;
        end
        default: if (!mem_read) mstate <= 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[6:4]);
    return line_blk.exists(idx) && (line_blk[idx] == int'(a[31:4]));
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_hits"},    32'(hit_count),   32'(h > 65535 ? 65535 : h));
    chk({tag, "_misses"},  32'(miss_count),  32'(m > 65535 ? 65535 : m));
    chk({tag, "_hits4"},   32'(hit_count4),  32'(h > 15 ? 15 : h));
    chk({tag, "_misses4"}, 32'(miss_count4), 32'(m > 15 ? 15 : m));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (cpu_busywait && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 100), 32'd1);
  endtask

  // One fetch held until served; ends just after the posedge that counts the hit
  task automatic fetch(input logic [31:0] a);
    bit exp_hit;
    exp_hit     = model_hit(a);
    cpu_read    = 1'b1;
    cpu_address = a;
    #1;
    chk("busy_first", 32'(cpu_busywait), 32'(!exp_hit));
    if (!exp_hit) begin
      tick();
      chk("miss_mem_read", 32'(mem_read), 32'd1);
      chk("miss_mem_addr", 32'(mem_address), 32'(a[31:4]));
      m++;
      wait_ready("refill");
      line_blk[int'(a[6:4])] = int'(a[31:4]);
    end
    chk("readdata", cpu_readdata, mem[a[11:2]]);
    tick();
    h++;
    chk_counters("fetch");
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    line_blk.delete();
    h = 0;
    m = 0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]  = 32'h00500093;
    mem[1]  = 32'h00506113;
    mem[32] = 32'h00000013;
    reset       = 1'b1;
    cpu_read    = 1'b0;
    cpu_address = 32'd0;
    h = 0;
    m = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(cpu_busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk_counters("rst");

    // Cold miss at 0x00
    fetch(32'h00);
    chk("t1_word", cpu_readdata, 32'h00500093);
    chk("t1_miss_count", 32'(miss_count), 32'd1);

    // Held hit at 0x04 for 20 cycles; narrow counter saturates at 15
    cpu_address = 32'h04;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t2_busy", 32'(cpu_busywait), 32'd0);
      chk("t2_mem_read", 32'(mem_read), 32'd0);
      chk("t2_word", cpu_readdata, 32'h00506113);
      tick();
      h++;
      chk("t2_hits", 32'(hit_count), 32'(h));
      chk("t2_hits4", 32'(hit_count4), 32'(h > 15 ? 15 : h));
    end
    chk("t6_hits4_sat", 32'(hit_count4), 32'd15);

    // Conflict on line 0
    fetch(32'h80);
    chk("t3_word", cpu_readdata, 32'h00000013);
    fetch(32'h00);
    chk("t3_miss_count", 32'(miss_count), 32'd3);

    // Reset in the middle of a refill
    cpu_read    = 1'b1;
    cpu_address = 32'h40;
    tick();
    chk("t4_mem_read_pre", 32'(mem_read), 32'd1);
    #2;
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    chk("t4_mem_read", 32'(mem_read), 32'd0);
    chk("t4_busy", 32'(cpu_busywait), 32'd0);
    chk("t4_hits", 32'(hit_count), 32'd0);
    chk("t4_misses", 32'(miss_count), 32'd0);
    do_reset();
    fetch(32'h00);
    chk("t4_miss_after", 32'(miss_count), 32'd1);
    fetch(32'h40);

    // Address change mid-refill: line 1 completes, then 0x20 misses separately
    cpu_read    = 1'b1;
    cpu_address = 32'h10;
    #1;
    chk("t5_busy", 32'(cpu_busywait), 32'd1);
    tick();
    chk("t5_mem_addr1", 32'(mem_address), 32'd1);
    m++;
    cpu_address = 32'h20;
    begin
      int n;
      n = 0;
      while (mem_read && n < 100) begin
        tick();
        n++;
      end
      chk("t5_timeout", 32'(n < 100), 32'd1);
    end
    line_blk[1] = 1;
    chk("t5_update_busy", 32'(cpu_busywait), 32'd1);
    chk("t5_update_mem_read", 32'(mem_read), 32'd0);
    tick();
    chk("t5_idle_busy", 32'(cpu_busywait), 32'd1);
    tick();
    chk("t5_mem_read2", 32'(mem_read), 32'd1);
    chk("t5_mem_addr2", 32'(mem_address), 32'd2);
    m++;
    wait_ready("t5_refill2");
    line_blk[2] = 2;
    chk("t5_word", cpu_readdata, mem[8]);
    tick();
    h++;
    chk_counters("t5");
    fetch(32'h10);
    fetch(32'h24);
    chk("t5_miss_total", 32'(miss_count), 32'd4);

    // Random fetches and idle gaps over 24 blocks
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cpu_read    = 1'b0;
        cpu_address = $urandom;
        #1;
        chk("idle_busy", 32'(cpu_busywait), 32'd0);
        chk("idle_mem_read", 32'(mem_read), 32'd0);
        tick();
        chk_counters("idle");
      end
      a = 32'($urandom_range(0, 23) * 16 + $urandom_range(0, 3) * 4);
      fetch(a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
